// File: rtl/zx_tape_pkg.sv
// zx_tape_pkg: shared types and constants for the ZX80/ZX81 quick-load engine.
// Loader states, Z80 opcodes of the spin-loop patch and the patch byte lookup.
package zx_tape_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        READY = 2'd1,
        COPY  = 2'd2,
        SPIN  = 2'd3
    } zx_state_e;

    localparam logic [7:0] OP_XOR_A = 8'hAF;
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_SCF   = 8'h37;
    localparam logic [7:0] OP_JR_NC = 8'h30;
    localparam logic [7:0] OP_JP    = 8'hC3;
    localparam logic [7:0] JR_BACK  = 8'hFD;

    localparam int PATCH_LEN = 7;

    // XOR A / (NOP|SCF) / JR NC,-3 / JP jmp : CPU spins until carry is set
    function automatic logic [7:0] patch_byte(
        input logic [2:0]  off,
        input logic        spin,
        input logic [15:0] jmp
    );
        logic [7:0] b;
        b = 8'hFF;
        case (off)
            3'd0:    b = OP_XOR_A;
            3'd1:    b = spin ? OP_SCF : OP_NOP;
            3'd2:    b = OP_JR_NC;
            3'd3:    b = JR_BACK;
            3'd4:    b = OP_JP;
            3'd5:    b = jmp[7:0];
            3'd6:    b = jmp[15:8];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/zx_tape_buf.sv
// zx_tape_buf: simple dual-port byte RAM holding the downloaded tape image.
// Write port fed by the download, read port has one cycle of registered latency.
module zx_tape_buf #(
    parameter int ADDR_W = 14
) (
    input  logic              clk_sys,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    // download write port
    always_ff @(posedge clk_sys) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // registered read port
    always_ff @(posedge clk_sys) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/zx_tape_loader.sv
// zx_tape_loader: buffers a .o/.p image, traps the ROM LOAD entry and streams
// the image into RAM while the CPU spins in a small patch served in place of ROM.
module zx_tape_loader #(
    parameter int ADDR_W    = 14,
    parameter int PATCH_LEN = 7
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W:0]   dl_addr,
    input  logic [7:0]        dl_data,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_m1_n,
    input  logic              ce_cpu_p,
    input  logic [15:0]       trap_addr,
    input  logic [15:0]       trap_end,
    input  logic [15:0]       jump_addr,
    input  logic [15:0]       dest_base,
    output logic              tape_ready,
    output logic              loader_active,
    output logic [7:0]        patch_data,
    output logic              ram_we,
    output logic [15:0]       ram_addr,
    output logic [7:0]        ram_data,
    output logic [ADDR_W:0]   bytes_done,
    output logic              done,
    output logic              overflow
);

    import zx_tape_pkg::*;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    zx_state_e       state;
    logic            dl_q;
    logic            m1_q;
    logic            ovf_q;
    logic            pend_q;
    logic [15:0]     wr_addr_q;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] len_base;
    logic [ADDR_W:0] len_nxt;
    logic [ADDR_W:0] dl_len;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] done_cnt;
    logic [7:0]      buf_q;
    logic [15:0]     off;
    logic            dl_rise;
    logic            dl_fall;
    logic            m1_edge;
    logic            trap_hit;
    logic            exit_hit;
    logic            issue;
    logic            copy_end;
    logic            buf_we;

    assign dl_rise  = dl_active & ~dl_q;
    assign dl_fall  = ~dl_active & dl_q;
    assign m1_edge  = m1_q & ~cpu_m1_n;
    assign trap_hit = m1_edge & (cpu_addr == trap_addr);
    assign exit_hit = m1_edge & ((cpu_addr < trap_addr) | (cpu_addr >= trap_end));
    assign buf_we   = dl_wr & ~dl_addr[ADDR_W];
    assign dl_len   = dl_addr + 1'b1;

    assign issue    = (state == COPY) & ce_cpu_p & (rd_ptr != len)
                    & ~exit_hit & ~dl_rise;
    assign copy_end = (state == COPY) & (rd_ptr == len) & ~pend_q;

    zx_tape_buf #(
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk_sys (clk_sys),
        .we      (buf_we),
        .waddr   (dl_addr[ADDR_W-1:0]),
        .wdata   (dl_data),
        .raddr   (rd_ptr[ADDR_W-1:0]),
        .rdata   (buf_q)
    );

    // image length: highest index written plus one, clamped to buffer depth
    always_comb begin
        len_base = dl_rise ? '0 : len;
        len_nxt  = len_base;
        if (dl_wr) begin
            if (dl_addr[ADDR_W]) begin
                len_nxt = DEPTH;
            end else if (dl_len > len_base) begin
                len_nxt = dl_len;
            end
        end
    end

    // loader state, copy pointer and write pipeline
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state     <= EMPTY;
            dl_q      <= 1'b0;
            m1_q      <= 1'b1;
            ovf_q     <= 1'b0;
            pend_q    <= 1'b0;
            wr_addr_q <= '0;
            len       <= '0;
            rd_ptr    <= '0;
            done_cnt  <= '0;
        end else begin
            dl_q   <= dl_active;
            m1_q   <= cpu_m1_n;
            len    <= len_nxt;
            ovf_q  <= (ovf_q & ~dl_rise) | (dl_wr & dl_addr[ADDR_W]);
            pend_q <= issue;
            if (issue) begin
                wr_addr_q <= dest_base + 16'(rd_ptr);
                rd_ptr    <= rd_ptr + 1'b1;
            end
            if (ram_we) begin
                done_cnt <= done_cnt + 1'b1;
            end
            if (dl_rise) begin
                state <= EMPTY;
            end else if (dl_fall) begin
                state <= (len_nxt != '0) ? READY : EMPTY;
            end else begin
                case (state)
                    READY: begin
                        if (trap_hit) begin
                            state    <= COPY;
                            rd_ptr   <= '0;
                            done_cnt <= '0;
                        end
                    end
                    COPY: begin
                        if (exit_hit) begin
                            state <= READY;
                        end else if (copy_end) begin
                            state <= SPIN;
                        end
                    end
                    SPIN: begin
                        if (exit_hit) begin
                            state <= READY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // patch window decode and output mapping
    always_comb begin
        off        = cpu_addr - trap_addr;
        patch_data = 8'hFF;
        if (loader_active && (off < 16'(PATCH_LEN))) begin
            patch_data = patch_byte(off[2:0], state == SPIN, jump_addr);
        end
    end

    assign tape_ready    = (state != EMPTY);
    assign loader_active = (state == COPY) | (state == SPIN);
    assign ram_we        = pend_q & ~dl_rise;
    assign ram_addr      = wr_addr_q;
    assign ram_data      = pend_q ? buf_q : 8'h00;
    assign bytes_done    = done_cnt;
    assign done          = copy_end & ~exit_hit & ~dl_rise;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_zx_tape_loader.sv
// tb_zx_tape_loader: directed checks of download, trap, copy, patch window,
// overflow, abort, download restart and reset behaviour of zx_tape_loader.
module tb_zx_tape_loader;

    localparam int AW = 4;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          dl_active = 1'b0;
    logic          dl_wr = 1'b0;
    logic [AW:0]   dl_addr = '0;
    logic [7:0]    dl_data = '0;
    logic [15:0]   cpu_addr = '0;
    logic          cpu_m1_n = 1'b1;
    logic          ce_cpu_p = 1'b0;
    logic [15:0]   trap_addr = 16'h0347;
    logic [15:0]   trap_end = 16'h03C3;
    logic [15:0]   jump_addr = 16'h0207;
    logic [15:0]   dest_base = 16'h4009;
    logic          tape_ready;
    logic          loader_active;
    logic [7:0]    patch_data;
    logic          ram_we;
    logic [15:0]   ram_addr;
    logic [7:0]    ram_data;
    logic [AW:0]   bytes_done;
    logic          done;
    logic          overflow;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int wb;
    int db;
    logic [15:0] wa [128];
    logic [7:0]  wd [128];

    zx_tape_loader #(
        .ADDR_W    (AW),
        .PATCH_LEN (7)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .dl_active     (dl_active),
        .dl_wr         (dl_wr),
        .dl_addr       (dl_addr),
        .dl_data       (dl_data),
        .cpu_addr      (cpu_addr),
        .cpu_m1_n      (cpu_m1_n),
        .ce_cpu_p      (ce_cpu_p),
        .trap_addr     (trap_addr),
        .trap_end      (trap_end),
        .jump_addr     (jump_addr),
        .dest_base     (dest_base),
        .tape_ready    (tape_ready),
        .loader_active (loader_active),
        .patch_data    (patch_data),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .bytes_done    (bytes_done),
        .done          (done),
        .overflow      (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // log RAM writes and done pulses mid-cycle
    always @(negedge clk_sys) begin
        if (ram_we === 1'b1) begin
            if (wr_cnt < 128) begin
                wa[wr_cnt] = ram_addr;
                wd[wr_cnt] = ram_data;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        cyc = cyc + 1;
        ce_cpu_p = ((cyc % 8) == 0);
    endtask

    task automatic download(input int n, input logic [7:0] b0,
                            input logic [7:0] step);
        dl_active = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            dl_wr   = 1'b1;
            dl_addr = (AW+1)'(i);
            dl_data = b0 + 8'(i) * step;
            tick();
        end
        dl_wr     = 1'b0;
        dl_active = 1'b0;
        tick();
        tick();
    endtask

    task automatic m1(input logic [15:0] a);
        cpu_addr = a;
        cpu_m1_n = 1'b0;
        tick();
        cpu_m1_n = 1'b1;
        tick();
    endtask

    task automatic wait_wr(input int target);
        for (int k = 0; k < 200 && wr_cnt < target; k++) tick();
        chk("wait_wr", 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 400 && done_cnt < target; k++) tick();
        chk("wait_done", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 32'(tape_ready), 32'd0);
        chk({tag, "_active"}, 32'(loader_active), 32'd0);
        chk({tag, "_patch"}, 32'(patch_data), 32'hFF);
        chk({tag, "_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_data"}, 32'(ram_data), 32'd0);
        chk({tag, "_bytes"}, 32'(bytes_done), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk_reset_outs("rst");
        reset_n = 1'b1;
        tick();

        // three byte image, trap, copy to 4009h
        download(3, 8'h11, 8'h11);
        chk("dl3_ready", 32'(tape_ready), 32'd1);
        chk("dl3_ovf", 32'(overflow), 32'd0);
        chk("dl3_inactive", 32'(loader_active), 32'd0);
        wb = wr_cnt;
        db = done_cnt;
        m1(16'h0347);
        chk("trap_active", 32'(loader_active), 32'd1);
        cpu_addr = 16'h0347; #1 chk("p0", 32'(patch_data), 32'hAF);
        cpu_addr = 16'h0348; #1 chk("p1_copy", 32'(patch_data), 32'h00);
        cpu_addr = 16'h0349; #1 chk("p2", 32'(patch_data), 32'h30);
        cpu_addr = 16'h034A; #1 chk("p3", 32'(patch_data), 32'hFD);
        cpu_addr = 16'h034B; #1 chk("p4", 32'(patch_data), 32'hC3);
        cpu_addr = 16'h034C; #1 chk("p5", 32'(patch_data), 32'h07);
        cpu_addr = 16'h034D; #1 chk("p6", 32'(patch_data), 32'h02);
        cpu_addr = 16'h034E; #1 chk("p7", 32'(patch_data), 32'hFF);
        cpu_addr = 16'h0348;
        wait_done(db + 1);
        tick();
        tick();
        chk("c3_writes", 32'(wr_cnt - wb), 32'd3);
        chk("c3_a0", 32'(wa[wb]), 32'h4009);
        chk("c3_d0", 32'(wd[wb]), 32'h11);
        chk("c3_a1", 32'(wa[wb+1]), 32'h400A);
        chk("c3_d1", 32'(wd[wb+1]), 32'h22);
        chk("c3_a2", 32'(wa[wb+2]), 32'h400B);
        chk("c3_d2", 32'(wd[wb+2]), 32'h33);
        chk("c3_done", 32'(done_cnt - db), 32'd1);
        chk("c3_bytes", 32'(bytes_done), 32'd3);
        chk("p1_spin", 32'(patch_data), 32'h37);
        chk("spin_active", 32'(loader_active), 32'd1);

        // exit from spin
        m1(16'h0100);
        chk("exit_active", 32'(loader_active), 32'd0);
        chk("exit_ready", 32'(tape_ready), 32'd1);
        chk("exit_patch", 32'(patch_data), 32'hFF);

        // abort mid-copy, then restart from the first byte
        wb = wr_cnt;
        db = done_cnt;
        m1(16'h0347);
        wait_wr(wb + 1);
        cpu_addr = 16'h0100;
        cpu_m1_n = 1'b0;
        tick();
        chk("abort_active", 32'(loader_active), 32'd0);
        cpu_m1_n = 1'b1;
        for (int k = 0; k < 40; k++) tick();
        chk("abort_writes", 32'(wr_cnt - wb), 32'd1);
        chk("abort_done", 32'(done_cnt - db), 32'd0);
        chk("abort_ready", 32'(tape_ready), 32'd1);
        wb = wr_cnt;
        db = done_cnt;
        m1(16'h0347);
        wait_done(db + 1);
        tick();
        chk("re_writes", 32'(wr_cnt - wb), 32'd3);
        chk("re_a0", 32'(wa[wb]), 32'h4009);
        chk("re_d0", 32'(wd[wb]), 32'h11);
        chk("re_bytes", 32'(bytes_done), 32'd3);

        // 20 byte image into a 16 byte buffer
        download(20, 8'hA0, 8'h01);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_ready", 32'(tape_ready), 32'd1);
        wb = wr_cnt;
        db = done_cnt;
        dest_base = 16'h4000;
        m1(16'h0347);
        wait_done(db + 1);
        tick();
        tick();
        chk("ovf_writes", 32'(wr_cnt - wb), 32'd16);
        chk("ovf_bytes", 32'(bytes_done), 32'd16);
        chk("ovf_a15", 32'(wa[wb+15]), 32'h400F);
        chk("ovf_d15", 32'(wd[wb+15]), 32'hAF);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // download restart during copy
        m1(16'h0100);
        wb = wr_cnt;
        m1(16'h0347);
        wait_wr(wb + 1);
        for (int k = 0; k < 20 && !ce_cpu_p; k++) tick();
        tick();
        chk("dl_pre_we", 32'(ram_we), 32'd1);
        dl_active = 1'b1;
        #1 chk("dl_rise_we", 32'(ram_we), 32'd0);
        tick();
        chk("dl_rise_ready", 32'(tape_ready), 32'd0);
        chk("dl_rise_active", 32'(loader_active), 32'd0);
        chk("dl_rise_ovf", 32'(overflow), 32'd0);
        dl_active = 1'b0;
        tick();
        tick();
        chk("zero_len_ready", 32'(tape_ready), 32'd0);

        // reset during copy, then a trap while empty
        dest_base = 16'h4009;
        download(3, 8'h11, 8'h11);
        wb = wr_cnt;
        m1(16'h0347);
        wait_wr(wb + 1);
        reset_n = 1'b0;
        tick();
        chk_reset_outs("mid_rst");
        reset_n = 1'b1;
        tick();
        wb = wr_cnt;
        m1(16'h0347);
        chk("empty_trap", 32'(loader_active), 32'd0);
        for (int k = 0; k < 30; k++) tick();
        chk("empty_writes", 32'(wr_cnt - wb), 32'd0);
        chk("empty_ready", 32'(tape_ready), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
